vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0: active level of the hs_o and vs_o sync pulses.
REQ-006 SHALL have parameters PIX_X_W and PIX_Y_W, default 12: widths of the x and y coordinates.
REQ-007 SHALL have port clk_25_i, input, 1 bit: pixel clock, the single clock.
REQ-008 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port en_i, input, 1 bit: synchronous run enable.
REQ-010 SHALL have port pix_x_o, output, PIX_X_W bits: horizontal pixel counter.
REQ-011 SHALL have port pix_y_o, output, PIX_Y_W bits: vertical line counter.
REQ-012 SHALL have ports hs_o and vs_o, output, 1 bit each: horizontal and vertical sync.
REQ-013 SHALL have port de_o, output, 1 bit: display enable, high in the visible area.
REQ-014 SHALL have ports line_start_o and frame_start_o, output, 1 bit each: single-cycle markers.
REQ-015 SHALL have port frame_cnt_o, output, 16 bits: frame counter.

Function
REQ-016 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; internal h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0.
REQ-017 SHALL define V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; v_cnt SHALL advance only on the h_cnt wrap, count 0..V_TOTAL-1, and wrap to 0.
REQ-018 SHALL register all outputs once, so the outputs in cycle n reflect h_cnt and v_cnt of cycle n-1 (latency 1).
REQ-019 SHALL drive pix_x_o = h_cnt and pix_y_o = v_cnt over the full range, including blanking; de_o qualifies validity.
REQ-020 SHALL assert de_o when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-021 SHALL drive hs_o = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-022 SHALL drive vs_o = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines, and ~VS_POL otherwise.
REQ-023 SHALL pulse line_start_o for one cycle with pix_x_o==0, on every line including blanking lines.
REQ-024 SHALL pulse frame_start_o for one cycle with pix_x_o==0 and pix_y_o==0.
REQ-025 SHALL, with en_i low, freeze the counters and hold all outputs; de_o, line_start_o and frame_start_o SHALL be forced to 0 while frozen.
REQ-026 SHALL, on en_i rising, resume from the frozen count with no skipped or repeated count.
REQ-027 SHALL fail elaboration if H_TOTAL > 2**PIX_X_W, V_TOTAL > 2**PIX_Y_W, or any porch or sync parameter is 0.

Reset
REQ-028 SHALL, with rst_n_i low (asynchronous), set h_cnt=0, v_cnt=0, pix_x_o=0, pix_y_o=0, de_o=0, hs_o=~HS_POL, vs_o=~VS_POL, line_start_o=0, frame_start_o=0, frame_cnt_o=0.
REQ-029 SHALL, on the first enabled edge after reset release, present pixel (0,0) with de_o=1, line_start_o=1 and frame_start_o=1.
REQ-030 SHALL, on reset asserted mid-frame, abort immediately and restart at (0,0) after release.

Configuration
REQ-031 SHALL, with macro VGA_FRAME_CNT_EN defined, increment frame_cnt_o by 1 (modulo 2**16) in the cycle frame_start_o is high, from the second frame onward.
REQ-032 SHALL, without VGA_FRAME_CNT_EN, tie frame_cnt_o to 0 and instantiate no counter logic.

Structure
REQ-033 SHALL place the 640x480@60 default timing constants, and a packed struct typedef holding {active, fp, sync, bp}, in shared package vga_timing_pkg.
REQ-034 SHALL use one sub-module, vga_axis_cnt (counter, wrap flag, active decode, sync decode), instantiated twice: horizontal with inc=1, vertical with inc=horizontal wrap.

Verification
REQ-035 SHALL cover: reset release, en_i=1 -> first output cycle x=0, y=0, de=1, frame_start=1; next cycle x=1, line_start=0.
REQ-036 SHALL cover: run one line with defaults -> hs_o low exactly for x=656..751 (96 cycles), de_o high for x=0..639, wrap 799->0 with y incremented.
REQ-037 SHALL cover: run one frame -> vs_o low for y=490..491 (1600 cycles), frame_start_o period exactly 420000 cycles.
REQ-038 SHALL cover: drop en_i for 10 cycles at x=300, y=100 -> outputs hold (300,100), de=0; on resume, x=301 follows.
REQ-039 SHALL cover: assert rst_n_i at x=500, y=200 -> outputs reach reset values asynchronously; on release, restart at (0,0).
REQ-040 SHALL cover: VGA_FRAME_CNT_EN defined, run 3 frames -> frame_cnt_o reads 0, 1, 2 at successive frame starts; undefined -> constant 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 default constants and the per-axis
// timing record {active, fp, sync, bp} used by the counters.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    localparam int unsigned H_ACTIVE_DEF = 32'd640;
    localparam int unsigned H_FP_DEF     = 32'd16;
    localparam int unsigned H_SYNC_DEF   = 32'd96;
    localparam int unsigned H_BP_DEF     = 32'd48;
    localparam int unsigned V_ACTIVE_DEF = 32'd480;
    localparam int unsigned V_FP_DEF     = 32'd10;
    localparam int unsigned V_SYNC_DEF   = 32'd2;
    localparam int unsigned V_BP_DEF     = 32'd33;

    localparam vga_axis_t VGA_H_640X480 = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_axis_t VGA_V_640X480 = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    function automatic int unsigned axis_total(vga_axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing output bundle: coordinates, syncs, display enable and markers.
interface vga_timing_gen_if #(
    parameter int unsigned PIX_X_W = 32'd12,
    parameter int unsigned PIX_Y_W = 32'd12
);
    logic [PIX_X_W-1:0] pix_x;
    logic [PIX_Y_W-1:0] pix_y;
    logic               hs;
    logic               vs;
    logic               de;
    logic               line_start;
    logic               frame_start;
    logic [15:0]        frame_cnt;

    modport master (output pix_x, pix_y, hs, vs, de, line_start, frame_start, frame_cnt);
    modport slave  (input  pix_x, pix_y, hs, vs, de, line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with wrap flag plus active and sync
// region decodes. Used for both the horizontal and vertical axis.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter vga_axis_t   CFG   = VGA_H_640X480,
    parameter int unsigned CNT_W = 32'd12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_r,
    output logic             wrap_s,
    output logic             active_s,
    output logic             sync_s
);

    localparam int unsigned      TOTAL    = axis_total(CFG);
    localparam int unsigned      SYNC_BEG = 32'(CFG.active) + 32'(CFG.fp);
    localparam int unsigned      SYNC_END = SYNC_BEG + 32'(CFG.sync);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] ACT_C    = CNT_W'(32'(CFG.active));
    localparam logic [CNT_W-1:0] SB_C     = CNT_W'(SYNC_BEG);
    localparam logic [CNT_W-1:0] SE_C     = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Position counter: advances on a run-qualified increment, wraps after the last position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (run && inc) begin
            if (wrap_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
        end
    end

    assign wrap_s   = (cnt_r == LAST_C);
    assign active_s = (cnt_r <  ACT_C);
    assign sync_s   = (cnt_r >= SB_C) && (cnt_r < SE_C);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with one cycle of output latency.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_X_W  = 32'd12,
    parameter int unsigned PIX_Y_W  = 32'd12
) (
    input  logic               clk_25_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    output logic [PIX_X_W-1:0] pix_x_o,
    output logic [PIX_Y_W-1:0] pix_y_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic               de_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [15:0]        frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vga_axis_t H_CFG = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_axis_t V_CFG = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

    if (H_FP == 32'd0 || H_SYNC == 32'd0 || H_BP == 32'd0 ||
        V_FP == 32'd0 || V_SYNC == 32'd0 || V_BP == 32'd0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    if ((64'(H_TOTAL) > (64'd1 << PIX_X_W)) || (64'(V_TOTAL) > (64'd1 << PIX_Y_W))) begin : g_bad_width
        $error("vga_timing_gen: line or frame total does not fit the coordinate width");
    end

    logic [PIX_X_W-1:0] h_cnt_s;
    logic [PIX_Y_W-1:0] v_cnt_s;
    logic               h_wrap_s;
    logic               v_wrap_unused_s;
    logic               h_active_s;
    logic               v_active_s;
    logic               h_sync_s;
    logic               v_sync_s;
    logic               h_first_s;
    logic               frame_first_s;

    vga_axis_cnt #(.CFG(H_CFG), .CNT_W(PIX_X_W)) u_h_axis (
        .clk      (clk_25_i),
        .rst_n    (rst_n_i),
        .run      (en_i),
        .inc      (1'b1),
        .cnt_r    (h_cnt_s),
        .wrap_s   (h_wrap_s),
        .active_s (h_active_s),
        .sync_s   (h_sync_s)
    );

    // The vertical axis steps once per line, on the horizontal wrap
    vga_axis_cnt #(.CFG(V_CFG), .CNT_W(PIX_Y_W)) u_v_axis (
        .clk      (clk_25_i),
        .rst_n    (rst_n_i),
        .run      (en_i),
        .inc      (h_wrap_s),
        .cnt_r    (v_cnt_s),
        .wrap_s   (v_wrap_unused_s),
        .active_s (v_active_s),
        .sync_s   (v_sync_s)
    );

    assign h_first_s     = (h_cnt_s == '0);
    assign frame_first_s = h_first_s && (v_cnt_s == '0);

    // Output stage: registered view of the counters; de and markers drop while frozen
    always_ff @(posedge clk_25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            de_o          <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            pix_x_o       <= h_cnt_s;
            pix_y_o       <= v_cnt_s;
            hs_o          <= h_sync_s ? HS_POL : ~HS_POL;
            vs_o          <= v_sync_s ? VS_POL : ~VS_POL;
            de_o          <= h_active_s && v_active_s;
            line_start_o  <= h_first_s;
            frame_start_o <= frame_first_s;
        end else begin
            de_o          <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic        seen_frame_r;
    logic [15:0] frame_cnt_r;

    // Frame counter: the first frame after reset reads 0, each later frame start adds one
    always_ff @(posedge clk_25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seen_frame_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else if (en_i && frame_first_s) begin
            seen_frame_r <= 1'b1;
            if (seen_frame_r) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_r;
`else
    assign frame_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, a small
// positive-polarity instance for frame, freeze and reset behaviour.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FCNT_ON = 1'b1;
`else
    localparam bit FCNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, en_a, rst_n_b, en_b;

    vga_timing_gen_if vif_a ();
    vga_timing_gen_if vif_b ();

    vga_timing_gen u_dut_a (
        .clk_25_i      (clk),
        .rst_n_i       (rst_n_a),
        .en_i          (en_a),
        .pix_x_o       (vif_a.pix_x),
        .pix_y_o       (vif_a.pix_y),
        .hs_o          (vif_a.hs),
        .vs_o          (vif_a.vs),
        .de_o          (vif_a.de),
        .line_start_o  (vif_a.line_start),
        .frame_start_o (vif_a.frame_start),
        .frame_cnt_o   (vif_a.frame_cnt)
    );

    // Small raster: 16 pixels x 10 lines, sync high-active
    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_b (
        .clk_25_i      (clk),
        .rst_n_i       (rst_n_b),
        .en_i          (en_b),
        .pix_x_o       (vif_b.pix_x),
        .pix_y_o       (vif_b.pix_y),
        .hs_o          (vif_b.hs),
        .vs_o          (vif_b.vs),
        .de_o          (vif_b.de),
        .line_start_o  (vif_b.line_start),
        .frame_start_o (vif_b.frame_start),
        .frame_cnt_o   (vif_b.frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_b(input int x, input int y);
        int n;
        n = 0;
        while (!(vif_b.pix_x == x[11:0] && vif_b.pix_y == y[11:0]) && n < 400) begin
            tick();
            n++;
        end
        chk("b_reach_point", (n < 400) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int x_bad, hs_lo, hs_first, hs_last, de_cnt, de_last;
    int fs_n, vs_act, vs_first_x, vs_first_y, hs_act, de_b, ls_b, vs_edge_bad, hold_bad;
    int fs_idx[4];
    int fcnt_at[4];
    logic prev_vs, held_hs;

    initial begin
        rst_n_a = 1'b0; en_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0;
        repeat (3) tick();

        // Reset state of the default instance
        chk("a_rst_x",    vif_a.pix_x, 0);
        chk("a_rst_y",    vif_a.pix_y, 0);
        chk("a_rst_de",   vif_a.de, 0);
        chk("a_rst_hs",   vif_a.hs, 1);
        chk("a_rst_vs",   vif_a.vs, 1);
        chk("a_rst_ls",   vif_a.line_start, 0);
        chk("a_rst_fs",   vif_a.frame_start, 0);
        chk("a_rst_fcnt", vif_a.frame_cnt, 0);

        // First line of the default 800-pixel line
        rst_n_a = 1'b1; en_a = 1'b1;
        x_bad = 0; hs_lo = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_last = -1;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (k == 0) begin
                chk("a_first_x",  vif_a.pix_x, 0);
                chk("a_first_y",  vif_a.pix_y, 0);
                chk("a_first_de", vif_a.de, 1);
                chk("a_first_ls", vif_a.line_start, 1);
                chk("a_first_fs", vif_a.frame_start, 1);
            end
            if (k == 1) begin
                chk("a_second_x",  vif_a.pix_x, 1);
                chk("a_second_ls", vif_a.line_start, 0);
                chk("a_second_fs", vif_a.frame_start, 0);
            end
            if (vif_a.pix_x != k[11:0]) x_bad++;
            if (vif_a.hs == 1'b0) begin
                if (hs_lo == 0) hs_first = int'(vif_a.pix_x);
                hs_last = int'(vif_a.pix_x);
                hs_lo++;
            end
            if (vif_a.de) begin
                de_cnt++;
                de_last = int'(vif_a.pix_x);
            end
        end
        chk("a_x_sequence", x_bad, 0);
        chk("a_hs_len",     hs_lo, 96);
        chk("a_hs_first",   hs_first, 656);
        chk("a_hs_last",    hs_last, 751);
        chk("a_de_len",     de_cnt, 640);
        chk("a_de_last",    de_last, 639);
        tick();
        chk("a_wrap_x",  vif_a.pix_x, 0);
        chk("a_wrap_y",  vif_a.pix_y, 1);
        chk("a_wrap_ls", vif_a.line_start, 1);
        chk("a_wrap_fs", vif_a.frame_start, 0);
        en_a = 1'b0;

        // Small instance: three full frames plus the fourth frame start
        rst_n_b = 1'b1; en_b = 1'b1;
        fs_n = 0; vs_act = 0; vs_first_x = -1; vs_first_y = -1;
        hs_act = 0; de_b = 0; ls_b = 0; vs_edge_bad = 0; prev_vs = 1'b0;
        for (int k = 0; k <= 480; k++) begin
            tick();
            if (vif_b.frame_start && fs_n < 4) begin
                fs_idx[fs_n]  = k;
                fcnt_at[fs_n] = int'(vif_b.frame_cnt);
                fs_n++;
            end
            if (k < 160) begin
                if (vif_b.vs) begin
                    if (vs_act == 0) begin
                        vs_first_x = int'(vif_b.pix_x);
                        vs_first_y = int'(vif_b.pix_y);
                    end
                    vs_act++;
                end
                if (vif_b.hs) hs_act++;
                if (vif_b.de) de_b++;
                if (vif_b.line_start) ls_b++;
            end
            if (k > 0 && vif_b.vs != prev_vs && vif_b.pix_x != 12'd0) vs_edge_bad++;
            prev_vs = vif_b.vs;
        end
        chk("b_fs_count", fs_n, 4);
        chk("b_fs_first", fs_idx[0], 0);
        for (int i = 1; i < 4; i++) chk("b_fs_period", fs_idx[i] - fs_idx[i-1], 160);
        for (int i = 0; i < 4; i++) chk("b_frame_cnt", fcnt_at[i], FCNT_ON ? i : 0);
        chk("b_vs_len",      vs_act, 32);
        chk("b_vs_first_y",  vs_first_y, 7);
        chk("b_vs_first_x",  vs_first_x, 0);
        chk("b_vs_mid_line", vs_edge_bad, 0);
        chk("b_hs_len",      hs_act, 30);
        chk("b_de_len",      de_b, 60);
        chk("b_ls_count",    ls_b, 10);

        // Freeze inside the visible area, then resume
        run_to_b(5, 3);
        chk("b_pre_freeze_de", vif_b.de, 1);
        held_hs = vif_b.hs;
        en_b = 1'b0;
        hold_bad = 0;
        repeat (10) begin
            tick();
            if (vif_b.pix_x != 12'd5 || vif_b.pix_y != 12'd3 || vif_b.de ||
                vif_b.line_start || vif_b.frame_start || vif_b.hs != held_hs) hold_bad++;
        end
        chk("b_freeze_hold", hold_bad, 0);
        en_b = 1'b1;
        tick();
        chk("b_resume_x",  vif_b.pix_x, 6);
        chk("b_resume_y",  vif_b.pix_y, 3);
        chk("b_resume_de", vif_b.de, 1);

        // Freeze on the last pixel of a line; resume must wrap exactly once
        run_to_b(15, 3);
        en_b = 1'b0;
        repeat (3) tick();
        chk("b_edge_hold_x",  vif_b.pix_x, 15);
        chk("b_edge_hold_ls", vif_b.line_start, 0);
        en_b = 1'b1;
        tick();
        chk("b_edge_resume_x",  vif_b.pix_x, 0);
        chk("b_edge_resume_y",  vif_b.pix_y, 4);
        chk("b_edge_resume_ls", vif_b.line_start, 1);

        // Asynchronous reset while both syncs are active
        run_to_b(13, 7);
        chk("b_pre_rst_hs", vif_b.hs, 1);
        chk("b_pre_rst_vs", vif_b.vs, 1);
        rst_n_b = 1'b0;
        #2;
        chk("b_rst_x",    vif_b.pix_x, 0);
        chk("b_rst_y",    vif_b.pix_y, 0);
        chk("b_rst_de",   vif_b.de, 0);
        chk("b_rst_hs",   vif_b.hs, 0);
        chk("b_rst_vs",   vif_b.vs, 0);
        chk("b_rst_fs",   vif_b.frame_start, 0);
        chk("b_rst_fcnt", vif_b.frame_cnt, 0);
        #1;
        rst_n_b = 1'b1;
        tick();
        chk("b_restart_x",    vif_b.pix_x, 0);
        chk("b_restart_y",    vif_b.pix_y, 0);
        chk("b_restart_de",   vif_b.de, 1);
        chk("b_restart_fs",   vif_b.frame_start, 1);
        chk("b_restart_fcnt", vif_b.frame_cnt, 0);
        tick();
        chk("b_restart_next_x", vif_b.pix_x, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
